// File: rtl/keypad_pkg.sv
// keypad_pkg: types and default key mapping shared by the keypad controller.
//   state_t     - debounce FSM states
//   frame_res_t - outcome of one full scan frame
//   DEF_*_CODE  - default key codes for fire / left / right
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    HELD,
    REL
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    KEY,
    GHOST
  } frame_res_t;

  localparam int DEF_FIRE_CODE  = 0;
  localparam int DEF_LEFT_CODE  = 8;
  localparam int DEF_RIGHT_CODE = 12;

endpackage

// File: rtl/keypad_row_scan.sv
// keypad_row_scan: drives the keypad rows one at a time and classifies each
// full pass over the rows as no key, exactly one key, or a ghost.
// Ports:
//   clk, rst      - clock, synchronous active-low reset
//   key_col       - column sense, active-low
//   key_row       - row drive, one-cold
//   frame_done    - high on the cycle holding the last sample of a frame
//   frame_result  - NONE / KEY / GHOST for that frame (valid with frame_done)
//   frame_code    - row*COLS+col of the single key (valid when KEY)
module keypad_row_scan
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 4,
  parameter int CW       = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] key_col,
  output logic [ROWS-1:0] key_row,
  output logic            frame_done,
  output frame_res_t      frame_result,
  output logic [CW-1:0]   frame_code
);

  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  logic [SW-1:0] slot_cnt;
  logic [RW-1:0] row_cnt;
  logic [1:0]    acc_cnt;
  logic [CW-1:0] acc_code;
  logic [1:0]    hits;
  logic [1:0]    tot;
  logic [2:0]    sum;
  logic [CW-1:0] hit_code;
  logic [CW-1:0] tot_code;
  logic          sample;

  assign sample = (slot_cnt == SLOT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_cnt <= '0;
      row_cnt  <= '0;
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (sample) begin
      slot_cnt <= '0;
      if (row_cnt == ROW_LAST) begin
        row_cnt  <= '0;
        acc_cnt  <= '0;
        acc_code <= '0;
      end else begin
        row_cnt  <= row_cnt + 1'b1;
        acc_cnt  <= tot;
        acc_code <= tot_code;
      end
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  always_comb begin
    key_row          = '1;
    key_row[row_cnt] = 1'b0;
  end

  // Closure count saturates at 2: anything beyond one key is a ghost, so the
  // exact number never matters.
  always_comb begin
    hits     = '0;
    hit_code = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!key_col[c]) begin
        if (hits != 2'd2) hits = hits + 2'd1;
        hit_code = CW'(row_cnt) * CW'(COLS) + CW'(c);
      end
    end
    sum      = {1'b0, acc_cnt} + {1'b0, hits};
    tot      = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    tot_code = (hits != 2'd0) ? hit_code : acc_code;
  end

  assign frame_done   = sample && (row_cnt == ROW_LAST);
  assign frame_code   = tot_code;
  assign frame_result = (tot == 2'd0) ? NONE : ((tot == 2'd1) ? KEY : GHOST);

endmodule

// File: rtl/keypad_ctrl.sv
// keypad_ctrl: R x C matrix keypad controller with frame-level debounce,
// ghost rejection, single-cycle key events, a saturating player position
// and a fire strobe.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-emit a held key after
// REPEAT_DELAY frames and then every REPEAT_RATE frames.
// Ports:
//   clk, rst   - clock, synchronous active-low reset
//   key_col    - column sense, active-low
//   key_row    - row drive, one-cold
//   key_valid  - one-cycle strobe per accepted press (or repeat)
//   key_code   - code of current / last key (row*COLS+col)
//   key_held   - debounced key currently down
//   play_pos   - saturating player position
//   fire       - one-cycle strobe when the fire key is accepted
//
// state | meaning
// IDLE  | no key, waiting for a single-key frame
// PEND  | candidate seen, counting identical frames
// HELD  | key accepted and still down
// REL   | key went away, counting release frames
module keypad_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 25'd8388608,
  parameter int DEBOUNCE     = 2,
  parameter int POS_W        = 3,
  parameter int POS_MIN      = 1,
  parameter int POS_MAX      = 6,
  parameter int POS_INIT     = 1,
  parameter int FIRE_CODE    = DEF_FIRE_CODE,
  parameter int LEFT_CODE    = DEF_LEFT_CODE,
  parameter int RIGHT_CODE   = DEF_RIGHT_CODE,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2,
  localparam int CW          = $clog2(ROWS*COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COLS-1:0]  key_col,
  output logic [ROWS-1:0]  key_row,
  output logic             key_valid,
  output logic [CW-1:0]    key_code,
  output logic             key_held,
  output logic [POS_W-1:0] play_pos,
  output logic             fire
);

  localparam logic [7:0]       DEB    = 8'(DEBOUNCE);
  localparam logic             DEB1   = (DEBOUNCE == 1);
  localparam logic [CW-1:0]    FIRE_C = CW'(FIRE_CODE);
  localparam logic [CW-1:0]    LEFT_C = CW'(LEFT_CODE);
  localparam logic [CW-1:0]    RGHT_C = CW'(RIGHT_CODE);
  localparam logic [POS_W-1:0] P_MIN  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] P_INIT = POS_W'(POS_INIT);

  logic          frame_done;
  frame_res_t    frame_result;
  logic [CW-1:0] frame_code;

  keypad_row_scan #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .CW       (CW)
  ) u_scan (
    .clk          (clk),
    .rst          (rst),
    .key_col      (key_col),
    .key_row      (key_row),
    .frame_done   (frame_done),
    .frame_result (frame_result),
    .frame_code   (frame_code)
  );

  state_t           state, state_nxt;
  logic [CW-1:0]    cand, cand_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [CW-1:0]    code_nxt;
  logic             held_nxt;
  logic             valid_nxt;
  logic             fire_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic             same;
  logic             accept;
  logic             rep_hit;
  logic             emit;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [7:0] REP_D = 8'(REPEAT_DELAY);
  localparam logic [7:0] REP_R = 8'(REPEAT_RATE);
  logic [7:0] rep_cnt, rep_cnt_nxt, rep_inc;
  logic       rep_first, rep_first_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_held  <= 1'b0;
      key_valid <= 1'b0;
      fire      <= 1'b0;
      play_pos  <= P_INIT;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      key_code  <= code_nxt;
      key_held  <= held_nxt;
      key_valid <= valid_nxt;
      fire      <= fire_nxt;
      play_pos  <= pos_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= rep_cnt_nxt;
      rep_first <= rep_first_nxt;
`endif
    end
  end

  assign same = (frame_result == KEY) && (frame_code == cand);

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    code_nxt  = key_code;
    held_nxt  = key_held;
    accept    = 1'b0;
    rep_hit   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_nxt   = rep_cnt;
    rep_first_nxt = rep_first;
    rep_inc       = rep_cnt + 8'd1;
`endif
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame_result == KEY) begin
            cand_nxt = frame_code;
            cnt_nxt  = 8'd1;
            if (DEB1) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end else begin
              state_nxt = PEND;
            end
          end
        end
        PEND: begin
          if (same) begin
            cnt_nxt = cnt + 8'd1;
            if (cnt_nxt == DEB) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
        HELD: begin
          if (same) begin
            cnt_nxt = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_inc == (rep_first ? REP_D : REP_R)) begin
              rep_hit       = 1'b1;
              rep_cnt_nxt   = '0;
              rep_first_nxt = 1'b0;
            end else begin
              rep_cnt_nxt = rep_inc;
            end
`endif
          end else begin
            cnt_nxt = 8'd1;
            // With single-frame debounce the first release frame already
            // satisfies the release count.
            if (DEB1) begin
              state_nxt = IDLE;
              held_nxt  = 1'b0;
            end else begin
              state_nxt = REL;
            end
          end
        end
        REL: begin
          if (same) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 8'd1;
            if (cnt_nxt == DEB) begin
              state_nxt = IDLE;
              held_nxt  = 1'b0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    if (state_nxt != HELD || accept) begin
      rep_cnt_nxt   = '0;
      rep_first_nxt = 1'b1;
    end
`endif
    if (accept) begin
      code_nxt = cand_nxt;
      held_nxt = 1'b1;
    end
  end

  assign emit = accept | rep_hit;

  always_comb begin
    valid_nxt = emit;
    fire_nxt  = emit && (code_nxt == FIRE_C);
    pos_nxt   = play_pos;
    if (emit && code_nxt == LEFT_C && play_pos > P_MIN) pos_nxt = play_pos - 1'b1;
    if (emit && code_nxt == RGHT_C && play_pos < P_MAX) pos_nxt = play_pos + 1'b1;
  end

endmodule
